// File: rtl/accum_sys_pkg.sv
// Shared defaults and port-array typedefs for the systolic accumulator subsystem.
package accum_sys_pkg;

  localparam int DEF_SYS_COL    = 4;
  localparam int DEF_ACCUM_SIZE = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_OUT_AW     = 8;
  localparam int DEF_ACCUM_ROW  = DEF_ACCUM_SIZE / DEF_SYS_COL;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_ACCUM_ROW);

  typedef logic [DEF_SYS_COL-1:0][DEF_DATA_WIDTH-1:0] data_vec_t;
  typedef logic [DEF_SYS_COL-1:0][DEF_ADDR_WIDTH-1:0] acc_addr_vec_t;
  typedef logic [DEF_SYS_COL-1:0][DEF_OUT_AW-1:0]     out_addr_vec_t;

endpackage

// File: rtl/accum.sv
// Per-column accumulator banks: read-modify-write accumulate plus a
// 1-cycle synchronous read port that holds when not enabled.
module accum import accum_sys_pkg::*; #(
  parameter int  SYS_COL    = DEF_SYS_COL,
  parameter int  ACCUM_ROW  = DEF_ACCUM_ROW,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [SYS_COL-1:0]                  wr_en,
  input  logic [SYS_COL-1:0][ADDR_WIDTH-1:0]  wr_addr,
  input  logic [SYS_COL-1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic [SYS_COL-1:0]                  rd_en,
  input  logic [SYS_COL-1:0][ADDR_WIDTH-1:0]  rd_addr,
  output logic [SYS_COL-1:0][DATA_WIDTH-1:0]  rd_data
);

  logic signed [DATA_WIDTH-1:0] mem [SYS_COL][ACCUM_ROW];

  // Plain two's-complement add; overflow wraps by design.
  function automatic logic signed [DATA_WIDTH-1:0] wrap_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  // Non-blocking read of mem gives the pre-write value on same-address collisions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < SYS_COL; j++) begin
        for (int r = 0; r < ACCUM_ROW; r++) begin
          mem[j][r] <= '0;
        end
      end
      rd_data <= '0;
    end else begin
      for (int j = 0; j < SYS_COL; j++) begin
        if (wr_en[j]) begin
          mem[j][wr_addr[j]] <= wrap_add(mem[j][wr_addr[j]], wr_data[j]);
        end
        if (rd_en[j]) begin
          rd_data[j] <= mem[j][rd_addr[j]];
        end
      end
    end
  end

endmodule

// File: rtl/accum_wr_ctrl.sv
// Skews the row-write strobe and address so column j sees them j cycles late,
// matching the diagonal wavefront of partial sums leaving the systolic array.
module accum_wr_ctrl import accum_sys_pkg::*; #(
  parameter int  SYS_COL    = DEF_SYS_COL,
  parameter int  ACCUM_ROW  = DEF_ACCUM_ROW,
  localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                wr_ctrl_clr,
  input  logic                                wr_en_in,
  input  logic [ADDR_WIDTH-1:0]               wr_addr_in,
  output logic [SYS_COL-1:0]                  wr_en_sk,
  output logic [SYS_COL-1:0][ADDR_WIDTH-1:0]  wr_addr_sk
);

  logic [SYS_COL-1:1]                 en_sr;
  logic [SYS_COL-1:1][ADDR_WIDTH-1:0] addr_sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_sr   <= '0;
      addr_sr <= '0;
    end else if (wr_ctrl_clr) begin
      en_sr   <= '0;
      addr_sr <= '0;
    end else begin
      en_sr[1]   <= wr_en_in;
      addr_sr[1] <= wr_addr_in;
      for (int k = 2; k < SYS_COL; k++) begin
        en_sr[k]   <= en_sr[k-1];
        addr_sr[k] <= addr_sr[k-1];
      end
    end
  end

  // Column 0 needs no delay, so it bypasses the shift register entirely.
  always_comb begin
    wr_en_sk      = '0;
    wr_addr_sk    = '0;
    wr_en_sk[0]   = wr_en_in;
    wr_addr_sk[0] = wr_addr_in;
    for (int k = 1; k < SYS_COL; k++) begin
      wr_en_sk[k]   = en_sr[k];
      wr_addr_sk[k] = addr_sr[k];
    end
  end

endmodule

// File: rtl/out_mem_arr.sv
// Output staging memory: one independent write/read bank per column,
// synchronous read with hold, read-before-write on collisions.
module out_mem_arr import accum_sys_pkg::*; #(
  parameter int SYS_COL    = DEF_SYS_COL,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_AW     = DEF_OUT_AW
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [SYS_COL-1:0]                  wr_en,
  input  logic [SYS_COL-1:0][OUT_AW-1:0]      wr_addr,
  input  logic [SYS_COL-1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic [SYS_COL-1:0]                  rd_en,
  input  logic [SYS_COL-1:0][OUT_AW-1:0]      rd_addr,
  output logic [SYS_COL-1:0][DATA_WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 2 ** OUT_AW;

  logic [DATA_WIDTH-1:0] mem [SYS_COL][DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < SYS_COL; j++) begin
        for (int a = 0; a < DEPTH; a++) begin
          mem[j][a] <= '0;
        end
      end
      rd_data <= '0;
    end else begin
      for (int j = 0; j < SYS_COL; j++) begin
        if (wr_en[j]) begin
          mem[j][wr_addr[j]] <= wr_data[j];
        end
        if (rd_en[j]) begin
          rd_data[j] <= mem[j][rd_addr[j]];
        end
      end
    end
  end

endmodule

// File: rtl/accum_sys.sv
// Accumulator subsystem top: write-skew control, accumulator banks and
// output memory banks for a SYS_COL-wide systolic array.
module accum_sys import accum_sys_pkg::*; #(
  parameter int  SYS_COL    = DEF_SYS_COL,
  parameter int  ACCUM_SIZE = DEF_ACCUM_SIZE,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  OUT_AW     = DEF_OUT_AW,
  localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL,
  localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                wr_ctrl_clr,
  input  logic                                wr_en_in,
  input  logic [ADDR_WIDTH-1:0]               wr_addr_in,
  input  logic [SYS_COL-1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic [SYS_COL-1:0]                  rd_en,
  input  logic [SYS_COL-1:0][ADDR_WIDTH-1:0]  rd_addr,
  output logic [SYS_COL-1:0][DATA_WIDTH-1:0]  rd_data,
  input  logic [SYS_COL-1:0]                  out_wr_en,
  input  logic [SYS_COL-1:0][OUT_AW-1:0]      out_wr_addr,
  input  logic [SYS_COL-1:0][DATA_WIDTH-1:0]  out_wr_data,
  input  logic [SYS_COL-1:0]                  out_rd_en,
  input  logic [SYS_COL-1:0][OUT_AW-1:0]      out_rd_addr,
  output logic [SYS_COL-1:0][DATA_WIDTH-1:0]  out_rd_data
);

  logic [SYS_COL-1:0]                 wr_en_sk;
  logic [SYS_COL-1:0][ADDR_WIDTH-1:0] wr_addr_sk;

  accum_wr_ctrl #(
    .SYS_COL   (SYS_COL),
    .ACCUM_ROW (ACCUM_ROW)
  ) u_wr_ctrl (
    .clk         (clk),
    .rstn        (rstn),
    .wr_ctrl_clr (wr_ctrl_clr),
    .wr_en_in    (wr_en_in),
    .wr_addr_in  (wr_addr_in),
    .wr_en_sk    (wr_en_sk),
    .wr_addr_sk  (wr_addr_sk)
  );

  accum #(
    .SYS_COL    (SYS_COL),
    .ACCUM_ROW  (ACCUM_ROW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_accum (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en_sk),
    .wr_addr (wr_addr_sk),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  out_mem_arr #(
    .SYS_COL    (SYS_COL),
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_AW     (OUT_AW)
  ) u_out_mem (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (out_wr_en),
    .wr_addr (out_wr_addr),
    .wr_data (out_wr_data),
    .rd_en   (out_rd_en),
    .rd_addr (out_rd_addr),
    .rd_data (out_rd_data)
  );

endmodule

// File: tb/tb_accum_sys.sv
// Scoreboard bench for accum_sys: a reference model of bank contents feeds
// a queue of expected read words that is drained one cycle after each read.
module tb_accum_sys;
  import accum_sys_pkg::*;

  localparam int COLS = DEF_SYS_COL;
  localparam int ROWS = DEF_ACCUM_ROW;
  localparam int AW   = DEF_ADDR_WIDTH;

  logic          clk;
  logic          rstn;
  logic          wr_ctrl_clr;
  logic          wr_en_in;
  logic [AW-1:0] wr_addr_in;
  data_vec_t     wr_data;
  logic [COLS-1:0] rd_en;
  acc_addr_vec_t rd_addr;
  data_vec_t     rd_data;
  logic [COLS-1:0] out_wr_en;
  out_addr_vec_t out_wr_addr;
  data_vec_t     out_wr_data;
  logic [COLS-1:0] out_rd_en;
  out_addr_vec_t out_rd_addr;
  data_vec_t     out_rd_data;

  typedef struct {
    int          col;
    int          row;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [COLS][ROWS];
  int          checks;
  int          errors;

  accum_sys dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_ctrl_clr (wr_ctrl_clr),
    .wr_en_in    (wr_en_in),
    .wr_addr_in  (wr_addr_in),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .out_wr_en   (out_wr_en),
    .out_wr_addr (out_wr_addr),
    .out_wr_data (out_wr_data),
    .out_rd_en   (out_rd_en),
    .out_rd_addr (out_rd_addr),
    .out_rd_data (out_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    wr_ctrl_clr = 1'b0;
    wr_en_in    = 1'b0;
    wr_addr_in  = '0;
    wr_data     = '0;
    rd_en       = '0;
    rd_addr     = '0;
    out_wr_en   = '0;
    out_wr_addr = '0;
    out_wr_data = '0;
    out_rd_en   = '0;
    out_rd_addr = '0;
  endtask

  task automatic model_clear();
    for (int j = 0; j < COLS; j++)
      for (int r = 0; r < ROWS; r++)
        model[j][r] = '0;
  endtask

  task automatic apply_reset();
    #2 rstn = 1'b0;
    model_clear();
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Reads every row across all columns back-to-back; expectations queued at issue.
  task automatic read_accum_rows();
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      rd_en = '1;
      for (int j = 0; j < COLS; j++) begin
        rd_addr[j] = AW'(r);
        e.col = j; e.row = r; e.val = model[j][r];
        sbq.push_back(e);
      end
      tick();
      for (int j = 0; j < COLS; j++) begin
        e = sbq.pop_front();
        checks++;
        if (rd_data[e.col] !== e.val) begin
          errors++;
          $display("FAIL accum_read col%0d row%0d got %h exp %h", e.col, e.row, rd_data[e.col], e.val);
        end
      end
    end
    rd_en = '0;
  endtask

  // Row r on wr_addr_in at cycle r; column j data 4r+j-1 presented at cycle r+j.
  task automatic run_pass();
    for (int c = 0; c < ROWS + COLS - 1; c++) begin
      wr_en_in   = (c < ROWS);
      wr_addr_in = (c < ROWS) ? AW'(c) : '0;
      for (int j = 0; j < COLS; j++) begin
        int r = c - j;
        wr_data[j] = (r >= 0 && r < ROWS) ? 32'(4 * r + j - 1) : 32'hDEAD_0000;
      end
      tick();
    end
    wr_en_in = 1'b0;
    wr_data  = '0;
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS; j++)
        model[j][r] = model[j][r] + 32'(4 * r + j - 1);
    idle(2);
  endtask

  task automatic test_reset();
    checks++;
    if (rd_data !== '0) begin
      errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data);
    end
    checks++;
    if (out_rd_data !== '0) begin
      errors++; $display("FAIL reset_out_rd_data got %h exp 0", out_rd_data);
    end
    read_accum_rows();
  endtask

  task automatic test_pass1();
    run_pass();
    read_accum_rows();
  endtask

  task automatic test_clr_repeat();
    wr_ctrl_clr = 1'b1;
    tick();
    wr_ctrl_clr = 1'b0;
    run_pass();
    read_accum_rows();
  endtask

  // Column j is fed 1 only at cycle t+j and 100 otherwise; any skew error shows up.
  task automatic test_skew();
    for (int c = 0; c <= COLS; c++) begin
      wr_en_in   = (c == 0);
      wr_addr_in = (c == 0) ? AW'(2) : '0;
      for (int j = 0; j < COLS; j++) wr_data[j] = (c == j) ? 32'd1 : 32'd100;
      tick();
    end
    clear_inputs();
    for (int j = 0; j < COLS; j++) model[j][2] = model[j][2] + 32'd1;
    idle(2);
    read_accum_rows();
  endtask

  // A clear one cycle after the strobe lets columns 0 and 1 write but drops 2 and 3.
  task automatic test_clr_in_flight();
    wr_en_in   = 1'b1;
    wr_addr_in = AW'(1);
    for (int j = 0; j < COLS; j++) wr_data[j] = 32'd7;
    tick();
    wr_en_in    = 1'b0;
    wr_addr_in  = '0;
    wr_ctrl_clr = 1'b1;
    tick();
    wr_ctrl_clr = 1'b0;
    idle(3);
    clear_inputs();
    model[0][1] = model[0][1] + 32'd7;
    model[1][1] = model[1][1] + 32'd7;
    idle(1);
    read_accum_rows();
  endtask

  task automatic test_rw_same_and_hold();
    logic [31:0] held [COLS];
    exp_t e;
    wr_en_in   = 1'b1;
    wr_addr_in = AW'(3);
    wr_data[0] = 32'd5;
    rd_en      = 4'h1;
    rd_addr[0] = AW'(3);
    e.col = 0; e.row = 3; e.val = model[0][3];
    sbq.push_back(e);
    tick();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0] !== e.val) begin
      errors++; $display("FAIL rw_same got %h exp %h", rd_data[0], e.val);
    end
    clear_inputs();
    model[0][3] = model[0][3] + 32'd5;
    idle(4);
    read_accum_rows();
    for (int j = 0; j < COLS; j++) held[j] = model[j][ROWS-1];
    rd_addr = '0;
    idle(3);
    for (int j = 0; j < COLS; j++) begin
      checks++;
      if (rd_data[j] !== held[j]) begin
        errors++; $display("FAIL rd_hold col%0d got %h exp %h", j, rd_data[j], held[j]);
      end
    end
  endtask

  task automatic col0_add(input int row, input logic [31:0] v);
    wr_en_in   = 1'b1;
    wr_addr_in = AW'(row);
    wr_data    = '0;
    wr_data[0] = v;
    tick();
    clear_inputs();
    model[0][row] = model[0][row] + v;
    idle(COLS);
  endtask

  task automatic test_overflow();
    col0_add(3, 32'h7FFF_FFFF - model[0][3]);
    col0_add(3, 32'd1);
    rd_en      = 4'h1;
    rd_addr[0] = AW'(3);
    tick();
    rd_en = '0;
    checks++;
    if (rd_data[0] !== 32'h8000_0000) begin
      errors++; $display("FAIL overflow got %h exp 80000000", rd_data[0]);
    end
    read_accum_rows();
  endtask

  task automatic test_reset_mid_flight();
    wr_en_in   = 1'b1;
    wr_addr_in = AW'(0);
    for (int j = 0; j < COLS; j++) wr_data[j] = 32'd9;
    tick();
    wr_en_in = 1'b0;
    apply_reset();
    checks++;
    if (rd_data !== '0) begin
      errors++; $display("FAIL reset_mid_rd_data got %h exp 0", rd_data);
    end
    idle(2);
    for (int c = 0; c < COLS; c++) begin
      wr_en_in   = (c == 0);
      wr_addr_in = '0;
      for (int j = 0; j < COLS; j++) wr_data[j] = (c == j) ? 32'(j + 1) : 32'd0;
      tick();
    end
    clear_inputs();
    for (int j = 0; j < COLS; j++) model[j][0] = 32'(j + 1);
    idle(1);
    read_accum_rows();
  endtask

  task automatic out_read(input logic [DEF_OUT_AW-1:0] a, input logic [31:0] v, input int tag);
    exp_t e;
    out_rd_en = '1;
    for (int j = 0; j < COLS; j++) begin
      out_rd_addr[j] = a;
      e.col = j; e.row = tag; e.val = v;
      sbq.push_back(e);
    end
    tick();
    out_rd_en = '0;
    for (int j = 0; j < COLS; j++) begin
      e = sbq.pop_front();
      checks++;
      if (out_rd_data[e.col] !== e.val) begin
        errors++;
        $display("FAIL out_read step%0d col%0d got %h exp %h", e.row, e.col, out_rd_data[e.col], e.val);
      end
    end
  endtask

  task automatic out_write_all(input logic [DEF_OUT_AW-1:0] a, input logic [31:0] v);
    out_wr_en = '1;
    for (int j = 0; j < COLS; j++) begin
      out_wr_addr[j] = a;
      out_wr_data[j] = v;
    end
    tick();
    out_wr_en = '0;
  endtask

  task automatic test_out_mem();
    exp_t e;
    out_write_all(8'd5, 32'd42);
    out_read(8'd5, 32'd42, 0);
    apply_reset();
    checks++;
    if (out_rd_data !== '0) begin
      errors++; $display("FAIL out_reset_data got %h exp 0", out_rd_data);
    end
    out_read(8'd5, 32'd0, 1);
    out_write_all(8'd5, 32'd42);
    out_read(8'd5, 32'd42, 2);
    // Same-address write and read in one cycle returns the old word.
    out_wr_en = '1;
    out_rd_en = '1;
    for (int j = 0; j < COLS; j++) begin
      out_wr_addr[j] = 8'd5;
      out_wr_data[j] = 32'd77;
      out_rd_addr[j] = 8'd5;
      e.col = j; e.row = 3; e.val = 32'd42;
      sbq.push_back(e);
    end
    tick();
    out_wr_en = '0;
    out_rd_en = '0;
    for (int j = 0; j < COLS; j++) begin
      e = sbq.pop_front();
      checks++;
      if (out_rd_data[e.col] !== e.val) begin
        errors++; $display("FAIL out_rw_same col%0d got %h exp %h", e.col, out_rd_data[e.col], e.val);
      end
    end
    idle(2);
    for (int j = 0; j < COLS; j++) begin
      checks++;
      if (out_rd_data[j] !== 32'd42) begin
        errors++; $display("FAIL out_hold col%0d got %h exp %h", j, out_rd_data[j], 32'd42);
      end
    end
    out_read(8'd5, 32'd77, 4);
    // Independent banks at distinct addresses.
    out_wr_en = '1;
    for (int j = 0; j < COLS; j++) begin
      out_wr_addr[j] = 8'(10 + j);
      out_wr_data[j] = 32'(100 + j);
    end
    tick();
    out_wr_en = '0;
    out_rd_en = '1;
    for (int j = 0; j < COLS; j++) out_rd_addr[j] = 8'(10 + j);
    tick();
    out_rd_en = '0;
    for (int j = 0; j < COLS; j++) begin
      checks++;
      if (out_rd_data[j] !== 32'(100 + j)) begin
        errors++; $display("FAIL out_bank col%0d got %h exp %h", j, out_rd_data[j], 32'(100 + j));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    clear_inputs();
    model_clear();
    idle(2);
    rstn = 1'b1;
    tick();
    test_reset();
    test_pass1();
    test_clr_repeat();
    test_skew();
    test_clr_in_flight();
    test_rw_same_and_hold();
    test_overflow();
    test_reset_mid_flight();
    test_out_mem();
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/accum_sys.md
ACCUM_SYS -- requirements
Module: accum_sys

Interface
REQ-001 SHALL have parameters: SYS_COL, default 4, number of systolic columns; ACCUM_SIZE, default 16, total accumulator words; DATA_WIDTH, default 32, word width; OUT_AW, default 8, output-memory address width.
REQ-002 SHALL derive localparams ACCUM_ROW = ACCUM_SIZE/SYS_COL and ADDR_WIDTH = $clog2(ACCUM_ROW).
REQ-003 SHALL use one clock and one asynchronous, active-low reset: clk input 1 (rising edge); rstn input 1 (async active-low).
REQ-004 SHALL have wr_ctrl_clr input 1: synchronous active-high clear of the skew pipeline only.
REQ-005 SHALL have wr_en_in input 1: unskewed row-write strobe.
REQ-006 SHALL have wr_addr_in input ADDR_WIDTH: unskewed row address.
REQ-007 SHALL have wr_data input [SYS_COL] x DATA_WIDTH: per-column partial sums, already skewed by the array.
REQ-008 SHALL have rd_en input SYS_COL; rd_addr input [SYS_COL] x ADDR_WIDTH; rd_data output [SYS_COL] x DATA_WIDTH.
REQ-009 SHALL have out_wr_en input SYS_COL; out_wr_addr input [SYS_COL] x OUT_AW; out_wr_data input [SYS_COL] x DATA_WIDTH.
REQ-010 SHALL have out_rd_en input SYS_COL; out_rd_addr input [SYS_COL] x OUT_AW; out_rd_data output [SYS_COL] x DATA_WIDTH.

Function
REQ-011 Skew: column j write enable and address SHALL equal wr_en_in and wr_addr_in delayed exactly j cycles; column 0 SHALL be combinational pass-through; columns 1..SYS_COL-1 SHALL use a shift register.
REQ-012 wr_ctrl_clr=1 SHALL zero all skew-register stages at the next edge; accumulator contents SHALL be unaffected.
REQ-013 Accumulate: on a rising edge with skewed enable j high, bank j SHALL store mem[j][addr_j] + wr_data[j].
REQ-014 Accumulate arithmetic SHALL be two's-complement DATA_WIDTH with wrap-around; no saturation.
REQ-015 Each column SHALL be an independent bank of ACCUM_ROW words; all columns MAY write in the same cycle.
REQ-016 Accumulator read SHALL be synchronous with 1-cycle latency: rd_data[j] <= mem[j][rd_addr[j]] when rd_en[j]=1; otherwise rd_data[j] SHALL hold its value.
REQ-017 Read and write of the same address in the same cycle SHALL return the pre-write value; reads SHALL not clear contents.
REQ-018 Out memory: SYS_COL banks of 2^OUT_AW words; bank j SHALL write out_wr_data[j] at out_wr_addr[j] when out_wr_en[j]=1.
REQ-019 Out memory read SHALL be 1-cycle synchronous and hold its value when out_rd_en[j]=0; same-address read/write SHALL return the old value.
REQ-020 Out-of-range accumulator addresses are impossible by construction (full ADDR_WIDTH range); no checking is required.

Reset
REQ-021 rstn low SHALL asynchronously zero all skew stages, all accumulator words, all out-memory words, rd_data and out_rd_data.
REQ-022 Reset asserted mid-operation SHALL discard in-flight skewed writes; the first write after release SHALL accumulate onto zero.

Structure
REQ-023 Shared package SHALL hold the default parameter values and the array typedefs (data vector, accumulator-address vector, out-address vector).
REQ-024 The block SHALL be split into sub-modules accum_wr_ctrl (skew pipeline), accum (accumulator banks) and out_mem_arr (output banks), instantiated by accum_sys.

Verification
REQ-025 Pass 1: rows 0..3 on wr_addr_in at consecutive cycles; column j data 4r+j-1 presented j cycles later -> row0 = {-1,0,1,2}, row3 = {11,12,13,14}.
REQ-026 Pulse wr_ctrl_clr, then repeat pass 1 -> rows hold 2x values: row0 = {-2,0,2,4}, row3 = {22,24,26,28}.
REQ-027 Skew: assert wr_en_in for one cycle at cycle t -> column j enable is high only at cycle t+j, and address matches.
REQ-028 Read all four rows with rd_en=4'hF -> rd_data valid 1 cycle after each address; holds while rd_en=0.
REQ-029 Overflow: accumulate 1 onto 32'h7FFFFFFF -> 32'h80000000.
REQ-030 Write out-memory address 5 = 42 in all banks, assert rstn low, then read -> 0; rewrite, read -> 42 one cycle after out_rd_en.
